// File: rtl/jzjpcc_mem_pkg.sv
// Shared types and constants for the memory stage: FSM states, funct3 size codes,
// lane-mask encodings and the byte-swap helpers used to reorder bus lanes.
package jzjpcc_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Bit 3 of the mask is byte offset 0 (bus bits [31:24]).
  localparam logic [3:0] MASK_OFF0  = 4'b1000;
  localparam logic [3:0] MASK_OFF1  = 4'b0100;
  localparam logic [3:0] MASK_OFF2  = 4'b0010;
  localparam logic [3:0] MASK_OFF3  = 4'b0001;
  localparam logic [3:0] MASK_HALF0 = 4'b1100;
  localparam logic [3:0] MASK_HALF2 = 4'b0011;
  localparam logic [3:0] MASK_WORD  = 4'b1111;

  function automatic logic [15:0] swap16(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  function automatic logic [31:0] swap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/jzjpcc_mem_access_unit_if.sv
// Data-bus req/ack interface between the memory stage (master) and the memory (slave).
interface jzjpcc_mem_access_unit_if;

  logic        busReq;
  logic        busWrite;
  logic [29:0] busAddress;
  logic [3:0]  busByteMask;
  logic [31:0] busWriteData;
  logic [31:0] busReadData;
  logic        busAck;

  modport master (
    output busReq,
    output busWrite,
    output busAddress,
    output busByteMask,
    output busWriteData,
    input  busReadData,
    input  busAck
  );

  modport slave (
    input  busReq,
    input  busWrite,
    input  busAddress,
    input  busByteMask,
    input  busWriteData,
    output busReadData,
    output busAck
  );

endinterface

// File: rtl/jzjpcc_load_formatter.sv
// Combinational load formatter: picks the addressed lane(s) from the bus word,
// restores little-endian byte order and sign/zero-extends to 32 bits.
module jzjpcc_load_formatter
  import jzjpcc_mem_pkg::*;
(
  input  logic [3:0]  byte_mask,
  input  logic [2:0]  funct3,
  input  logic [31:0] read_data,
  output logic [31:0] load_result
);

  logic [7:0]  lane;
  logic        lane_ok;
  logic [15:0] half;
  logic        half_ok;
  logic        is_unsigned;

  function automatic logic [31:0] extend8(input logic [7:0] v, input logic zero_ext);
    logic signed [7:0]  s;
    logic signed [31:0] w;
    s = v;
    w = s;
    return zero_ext ? {24'h000000, v} : w;
  endfunction

  function automatic logic [31:0] extend16(input logic [15:0] v, input logic zero_ext);
    logic signed [15:0] s;
    logic signed [31:0] w;
    s = v;
    w = s;
    return zero_ext ? {16'h0000, v} : w;
  endfunction

  assign is_unsigned = funct3[2];

  always_comb begin
    lane    = 8'h00;
    lane_ok = 1'b1;
    case (byte_mask)
      MASK_OFF0: lane = read_data[31:24];
      MASK_OFF1: lane = read_data[23:16];
      MASK_OFF2: lane = read_data[15:8];
      MASK_OFF3: lane = read_data[7:0];
      default:   lane_ok = 1'b0;
    endcase
  end

  always_comb begin
    half    = 16'h0000;
    half_ok = 1'b1;
    case (byte_mask)
      MASK_HALF0: half = swap16(read_data[31:16]);
      MASK_HALF2: half = swap16(read_data[15:0]);
      default:    half_ok = 1'b0;
    endcase
  end

  // Unsupported size or a mask that does not match the size yields zero.
  always_comb begin
    load_result = 32'h0000_0000;
    case (funct3[1:0])
      SIZE_BYTE: if (lane_ok) load_result = extend8(lane, is_unsigned);
      SIZE_HALF: if (half_ok) load_result = extend16(half, is_unsigned);
      SIZE_WORD: if (byte_mask == MASK_WORD) load_result = swap32(read_data);
      default:   load_result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/jzjpcc_mem_access_unit.sv
// Memory stage: latches one load/store from execute, runs it on the req/ack data bus,
// stalls execute while waiting and registers formatted load results for writeback.
module jzjpcc_mem_access_unit
  import jzjpcc_mem_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        memOpValid_execute,
  input  logic        memWrite_execute,
  input  logic [2:0]  funct3_execute,
  input  logic [29:0] memAddress_execute,
  input  logic [3:0]  memByteMask_execute,
  input  logic [31:0] memDataToWrite_execute,
  input  logic [4:0]  rdAddress_execute,
  output logic        stall,
  jzjpcc_mem_access_unit_if.master bus,
  output logic        loadValid_memory,
  output logic [31:0] loadData_memory,
  output logic [4:0]  rdAddress_memory
);

  state_t      state;
  logic        accept;
  logic        write_p1;
  logic [2:0]  funct3_p1;
  logic [29:0] addr_p1;
  logic [3:0]  mask_p1;
  logic [31:0] wdata_p1;
  logic [4:0]  rd_p1;
  logic [31:0] load_result;

  // A new op is taken when idle, or on the ack edge of the current one (no bubble).
  assign accept = memOpValid_execute & ((state == IDLE) | bus.busAck);

  assign stall            = (state == BUSY) & ~bus.busAck;
  assign bus.busReq       = (state == BUSY);
  assign bus.busWrite     = (state == BUSY) & write_p1;
  assign bus.busAddress   = addr_p1;
  assign bus.busByteMask  = mask_p1;
  assign bus.busWriteData = wdata_p1;

  jzjpcc_load_formatter u_load_formatter (
    .byte_mask   (mask_p1),
    .funct3      (funct3_p1),
    .read_data   (bus.busReadData),
    .load_result (load_result)
  );

  // Stage p1: latched copy of the execute op, held stable on the bus until ack.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_p1  <= 1'b0;
      funct3_p1 <= 3'b000;
      addr_p1   <= 30'h0;
      mask_p1   <= 4'h0;
      wdata_p1  <= 32'h0;
      rd_p1     <= 5'h0;
    end else if (accept) begin
      write_p1  <= memWrite_execute;
      funct3_p1 <= funct3_execute;
      addr_p1   <= memAddress_execute;
      mask_p1   <= memByteMask_execute;
      wdata_p1  <= memDataToWrite_execute;
      rd_p1     <= rdAddress_execute;
    end
  end

  // Stage p2: FSM and registered writeback result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      loadValid_memory <= 1'b0;
      loadData_memory  <= 32'h0;
      rdAddress_memory <= 5'h0;
    end else begin
      loadValid_memory <= 1'b0;
      case (state)
        IDLE: begin
          if (memOpValid_execute) state <= BUSY;
        end
        BUSY: begin
          if (bus.busAck) begin
            if (!write_p1) begin
              loadValid_memory <= 1'b1;
              loadData_memory  <= load_result;
              rdAddress_memory <= rd_p1;
            end
            if (!memOpValid_execute) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jzjpcc_mem_access_unit.sv
// Directed bench for the memory stage: loads of every size, stores with wait states,
// back-to-back ops and reset in the middle of a transaction.
module tb_jzjpcc_mem_access_unit;

  logic        clock;
  logic        reset_n;
  logic        memOpValid_execute;
  logic        memWrite_execute;
  logic [2:0]  funct3_execute;
  logic [29:0] memAddress_execute;
  logic [3:0]  memByteMask_execute;
  logic [31:0] memDataToWrite_execute;
  logic [4:0]  rdAddress_execute;
  logic        stall;
  logic        loadValid_memory;
  logic [31:0] loadData_memory;
  logic [4:0]  rdAddress_memory;

  int checks = 0;
  int errors = 0;

  jzjpcc_mem_access_unit_if bus_if ();

  jzjpcc_mem_access_unit dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .memOpValid_execute     (memOpValid_execute),
    .memWrite_execute       (memWrite_execute),
    .funct3_execute         (funct3_execute),
    .memAddress_execute     (memAddress_execute),
    .memByteMask_execute    (memByteMask_execute),
    .memDataToWrite_execute (memDataToWrite_execute),
    .rdAddress_execute      (rdAddress_execute),
    .stall                  (stall),
    .bus                    (bus_if),
    .loadValid_memory       (loadValid_memory),
    .loadData_memory        (loadData_memory),
    .rdAddress_memory       (rdAddress_memory)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_op(input logic wr, input logic [2:0] f3, input logic [29:0] addr,
                          input logic [3:0] mask, input logic [31:0] wdata, input logic [4:0] rd);
    memOpValid_execute     = 1'b1;
    memWrite_execute       = wr;
    funct3_execute         = f3;
    memAddress_execute     = addr;
    memByteMask_execute    = mask;
    memDataToWrite_execute = wdata;
    rdAddress_execute      = rd;
  endtask

  // Single load with zero-wait ack; result must appear the cycle after the ack edge.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [3:0] mask,
                         input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] exp);
    drive_op(1'b0, f3, 30'h0000_0100, mask, 32'h0, rd);
    tick();
    memOpValid_execute = 1'b0;
    chk({tag, "_req"}, {31'h0, bus_if.busReq}, 32'h1);
    chk({tag, "_mask"}, {28'h0, bus_if.busByteMask}, {28'h0, mask});
    bus_if.busReadData = rdata;
    bus_if.busAck      = 1'b1;
    #1;
    chk({tag, "_stall_ack"}, {31'h0, stall}, 32'h0);
    tick();
    bus_if.busAck = 1'b0;
    chk({tag, "_valid"}, {31'h0, loadValid_memory}, 32'h1);
    chk({tag, "_data"}, loadData_memory, exp);
    chk({tag, "_rd"}, {27'h0, rdAddress_memory}, {27'h0, rd});
    chk({tag, "_req_drop"}, {31'h0, bus_if.busReq}, 32'h0);
    tick();
    chk({tag, "_pulse"}, {31'h0, loadValid_memory}, 32'h0);
  endtask

  initial begin
    reset_n                = 1'b0;
    memOpValid_execute     = 1'b0;
    memWrite_execute       = 1'b0;
    funct3_execute         = 3'b000;
    memAddress_execute     = 30'h0;
    memByteMask_execute    = 4'h0;
    memDataToWrite_execute = 32'h0;
    rdAddress_execute      = 5'h0;
    bus_if.busReadData     = 32'h0;
    bus_if.busAck          = 1'b0;
    tick();
    tick();

    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_req", {31'h0, bus_if.busReq}, 32'h0);
    chk("rst_write", {31'h0, bus_if.busWrite}, 32'h0);
    chk("rst_valid", {31'h0, loadValid_memory}, 32'h0);
    chk("rst_data", loadData_memory, 32'h0);
    chk("rst_rd", {27'h0, rdAddress_memory}, 32'h0);
    chk("rst_addr", {2'b00, bus_if.busAddress}, 32'h0);
    chk("rst_bmask", {28'h0, bus_if.busByteMask}, 32'h0);
    chk("rst_wdata", bus_if.busWriteData, 32'h0);
    reset_n = 1'b1;

    // Ack while idle must do nothing.
    bus_if.busAck = 1'b1;
    tick();
    bus_if.busAck = 1'b0;
    chk("idle_ack_valid", {31'h0, loadValid_memory}, 32'h0);
    chk("idle_ack_req", {31'h0, bus_if.busReq}, 32'h0);

    // LW with address/stall checks in the request cycle.
    drive_op(1'b0, 3'b010, 30'h0000_1234, 4'b1111, 32'h0, 5'd7);
    tick();
    memOpValid_execute = 1'b0;
    chk("lw_addr", {2'b00, bus_if.busAddress}, 32'h0000_1234);
    chk("lw_write", {31'h0, bus_if.busWrite}, 32'h0);
    chk("lw_stall", {31'h0, stall}, 32'h1);
    bus_if.busReadData = 32'h7856_3412;
    bus_if.busAck      = 1'b1;
    #1;
    chk("lw_stall_ack", {31'h0, stall}, 32'h0);
    tick();
    bus_if.busAck = 1'b0;
    chk("lw_valid", {31'h0, loadValid_memory}, 32'h1);
    chk("lw_data", loadData_memory, 32'h1234_5678);
    chk("lw_rd", {27'h0, rdAddress_memory}, 32'd7);
    tick();
    chk("lw_pulse", {31'h0, loadValid_memory}, 32'h0);
    chk("lw_data_kept", loadData_memory, 32'h1234_5678);

    do_load("lb1",  3'b000, 4'b0100, 5'd1,  32'h00F0_0000, 32'hFFFF_FFF0);
    do_load("lbu1", 3'b100, 4'b0100, 5'd2,  32'h00F0_0000, 32'h0000_00F0);
    do_load("lb3",  3'b000, 4'b0001, 5'd3,  32'h0000_007F, 32'h0000_007F);
    do_load("lh2",  3'b001, 4'b0011, 5'd4,  32'h0000_34A2, 32'hFFFF_A234);
    do_load("lhu2", 3'b101, 4'b0011, 5'd5,  32'h0000_34A2, 32'h0000_A234);
    do_load("lh0",  3'b001, 4'b1100, 5'd6,  32'h3412_0000, 32'h0000_1234);
    do_load("badsz", 3'b011, 4'b1111, 5'd8, 32'hFFFF_FFFF, 32'h0);
    do_load("badmask", 3'b000, 4'b1010, 5'd9, 32'hFFFF_FFFF, 32'h0);

    // SW with three wait states.
    drive_op(1'b1, 3'b010, 30'h2AAA_AAAA, 4'b1111, 32'hDEAD_BEEF, 5'd0);
    tick();
    memOpValid_execute = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("sw_req", {31'h0, bus_if.busReq}, 32'h1);
      chk("sw_write", {31'h0, bus_if.busWrite}, 32'h1);
      chk("sw_addr", {2'b00, bus_if.busAddress}, 32'h2AAA_AAAA);
      chk("sw_wdata", bus_if.busWriteData, 32'hDEAD_BEEF);
      chk("sw_stall", {31'h0, stall}, 32'h1);
      chk("sw_novalid", {31'h0, loadValid_memory}, 32'h0);
      tick();
    end
    bus_if.busAck = 1'b1;
    #1;
    chk("sw_req4", {31'h0, bus_if.busReq}, 32'h1);
    chk("sw_addr4", {2'b00, bus_if.busAddress}, 32'h2AAA_AAAA);
    chk("sw_wdata4", bus_if.busWriteData, 32'hDEAD_BEEF);
    chk("sw_stall4", {31'h0, stall}, 32'h0);
    tick();
    bus_if.busAck = 1'b0;
    chk("sw_done_valid", {31'h0, loadValid_memory}, 32'h0);
    chk("sw_done_req", {31'h0, bus_if.busReq}, 32'h0);
    chk("sw_done_write", {31'h0, bus_if.busWrite}, 32'h0);

    // Two loads back to back with zero-wait acks.
    drive_op(1'b0, 3'b010, 30'h0000_0010, 4'b1111, 32'h0, 5'd3);
    tick();
    drive_op(1'b0, 3'b000, 30'h0000_0011, 4'b1000, 32'h0, 5'd4);
    bus_if.busReadData = 32'h1122_3344;
    bus_if.busAck      = 1'b1;
    #1;
    chk("b2b_stall1", {31'h0, stall}, 32'h0);
    tick();
    memOpValid_execute = 1'b0;
    bus_if.busReadData = 32'h8000_0000;
    chk("b2b_valid1", {31'h0, loadValid_memory}, 32'h1);
    chk("b2b_data1", loadData_memory, 32'h4433_2211);
    chk("b2b_rd1", {27'h0, rdAddress_memory}, 32'd3);
    chk("b2b_req2", {31'h0, bus_if.busReq}, 32'h1);
    chk("b2b_addr2", {2'b00, bus_if.busAddress}, 32'h0000_0011);
    chk("b2b_stall2", {31'h0, stall}, 32'h0);
    tick();
    bus_if.busAck = 1'b0;
    chk("b2b_valid2", {31'h0, loadValid_memory}, 32'h1);
    chk("b2b_data2", loadData_memory, 32'hFFFF_FF80);
    chk("b2b_rd2", {27'h0, rdAddress_memory}, 32'd4);
    chk("b2b_req_drop", {31'h0, bus_if.busReq}, 32'h0);
    tick();
    chk("b2b_pulse", {31'h0, loadValid_memory}, 32'h0);

    // Reset while busy drops the op.
    drive_op(1'b0, 3'b010, 30'h0000_0040, 4'b1111, 32'h0, 5'd9);
    tick();
    memOpValid_execute = 1'b0;
    chk("rmt_req_before", {31'h0, bus_if.busReq}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rmt_req_async", {31'h0, bus_if.busReq}, 32'h0);
    chk("rmt_stall_async", {31'h0, stall}, 32'h0);
    tick();
    reset_n            = 1'b1;
    bus_if.busReadData = 32'h7856_3412;
    bus_if.busAck      = 1'b1;
    tick();
    bus_if.busAck = 1'b0;
    chk("rmt_valid", {31'h0, loadValid_memory}, 32'h0);
    chk("rmt_req", {31'h0, bus_if.busReq}, 32'h0);
    tick();
    chk("rmt_valid2", {31'h0, loadValid_memory}, 32'h0);
    chk("rmt_data", loadData_memory, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
